// File: rtl/card_board_sched.sv
// ---------------------------------------------------------------------------
// card_board_sched
//   Board-level scheduler for the single shared card drawer. Stores the face
//   id and face-up flag for every board slot and a dirty bit per slot. It
//   serialises redraws by picking dirty slots in round-robin order, presenting
//   the slot origin, face and show flag to the drawer, pulsing draw and then
//   waiting for the drawer's done pulse (bounded by a timeout).
//
// Ports
//   Clock        in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   load         in   write face id into load_slot (clears show, marks dirty)
//   load_slot    in   slot index for load
//   load_face    in   face id 0..7
//   flip         in   write show flag into flip_slot (marks dirty)
//   flip_slot    in   slot index for flip
//   flip_show    in   1 = face up, 0 = card back
//   redraw_all   in   mark every slot dirty
//   drawer_done  in   drawer finished pulse
//   draw         out  one-cycle start pulse to the drawer
//   org_x/org_y  out  top-left pixel of the slot being drawn
//   card_num     out  face id of the slot being drawn
//   show         out  show flag of the slot being drawn
//   busy         out  any slot dirty or a draw in progress
//   frame_done   out  one-cycle pulse when the last dirty bit clears
//   timeout_err  out  sticky flag: drawer did not answer in time
// ---------------------------------------------------------------------------
module card_board_sched #(
    parameter int NSLOT   = 16,
    parameter int COLS    = 4,
    parameter int nX      = 8,
    parameter int nY      = 7,
    parameter int X0      = 8,
    parameter int Y0      = 10,
    parameter int PITCH_X = 20,
    parameter int PITCH_Y = 24,
    parameter int TIMEOUT = 1023,
    localparam int SW     = $clog2(NSLOT)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load,
    input  logic [SW-1:0] load_slot,
    input  logic [2:0]    load_face,
    input  logic          flip,
    input  logic [SW-1:0] flip_slot,
    input  logic          flip_show,
    input  logic          redraw_all,
    input  logic          drawer_done,
    output logic          draw,
    output logic [nX-1:0] org_x,
    output logic [nY-1:0] org_y,
    output logic [2:0]    card_num,
    output logic          show,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        face_r [NSLOT];
    logic [NSLOT-1:0]  face_up_r;
    logic [NSLOT-1:0]  dirty_r, dirty_s, clr_s, set_s;
    logic [SW-1:0]     rr_r, rr_s, cur_r, cur_s, pick_s;
    logic              found_s, tmo_hit_s;
    logic [TW-1:0]     tmo_r, tmo_s;

    logic              draw_r, show_r, busy_r, frame_done_r, timeout_err_r;
    logic [nX-1:0]     org_x_r;
    logic [nY-1:0]     org_y_r;
    logic [2:0]        card_num_r;

    function automatic logic [nX-1:0] org_x_of(input logic [SW-1:0] slot);
        logic [31:0] col_v;
        logic [31:0] sum_v;
        col_v = 32'(slot) % 32'(COLS);
        sum_v = 32'(X0) + col_v * 32'(PITCH_X);
        return sum_v[nX-1:0];
    endfunction

    function automatic logic [nY-1:0] org_y_of(input logic [SW-1:0] slot);
        logic [31:0] row_v;
        logic [31:0] sum_v;
        row_v = 32'(slot) / 32'(COLS);
        sum_v = 32'(Y0) + row_v * 32'(PITCH_Y);
        return sum_v[nY-1:0];
    endfunction

    // Round-robin search: first dirty slot at or after the rr pointer, wrapping.
    always_comb begin
        logic [SW-1:0] idx_v;
        found_s = 1'b0;
        pick_s  = {SW{1'b0}};
        idx_v   = {SW{1'b0}};
        for (int i = 0; i < NSLOT; i++) begin
            idx_v = rr_r + SW'(i);
            if (!found_s && dirty_r[idx_v]) begin
                found_s = 1'b1;
                pick_s  = idx_v;
            end else begin
                pick_s  = pick_s;
            end
        end
    end

    // Dirty-set requests from game logic for this cycle.
    always_comb begin
        set_s = {NSLOT{1'b0}};
        if (redraw_all) begin
            set_s = {NSLOT{1'b1}};
        end else begin
            set_s = {NSLOT{1'b0}};
        end
        if (load) begin
            set_s[load_slot] = 1'b1;
        end else begin
            set_s = set_s;
        end
        if (flip) begin
            set_s[flip_slot] = 1'b1;
        end else begin
            set_s = set_s;
        end
    end

    // Scheduler next-state logic; done takes priority over a coincident timeout.
    always_comb begin
        state_s   = state_r;
        rr_s      = rr_r;
        cur_s     = cur_r;
        tmo_s     = tmo_r;
        clr_s     = {NSLOT{1'b0}};
        tmo_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_ISSUE;
                    cur_s   = pick_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                tmo_s   = {TW{1'b0}};
            end
            ST_WAIT: begin
                if (drawer_done) begin
                    clr_s[cur_r] = 1'b1;
                    rr_s         = cur_r + SW'(1);
                    state_s      = ST_IDLE;
                end else if (tmo_r == TW'(TIMEOUT)) begin
                    tmo_hit_s = 1'b1;
                    rr_s      = cur_r + SW'(1);
                    state_s   = ST_IDLE;
                end else begin
                    tmo_s = tmo_r + TW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // A set in the same cycle as the clear keeps the slot dirty.
    assign dirty_s = (dirty_r & ~clr_s) | set_s;

    // Scheduler state, pointers, timeout counter and dirty bits.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
            rr_r    <= {SW{1'b0}};
            cur_r   <= {SW{1'b0}};
            tmo_r   <= {TW{1'b0}};
            dirty_r <= {NSLOT{1'b1}};
        end else begin
            state_r <= state_s;
            rr_r    <= rr_s;
            cur_r   <= cur_s;
            tmo_r   <= tmo_s;
            dirty_r <= dirty_s;
        end
    end

    // Board contents; the later flip assignment gives flip priority on show.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NSLOT; i++) begin
                face_r[i] <= 3'd0;
            end
            face_up_r <= {NSLOT{1'b0}};
        end else begin
            if (load) begin
                face_r[load_slot]    <= load_face;
                face_up_r[load_slot] <= 1'b0;
            end
            if (flip) begin
                face_up_r[flip_slot] <= flip_show;
            end
        end
    end

    // Registered drawer interface and status outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            draw_r        <= 1'b0;
            org_x_r       <= {nX{1'b0}};
            org_y_r       <= {nY{1'b0}};
            card_num_r    <= 3'd0;
            show_r        <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            draw_r <= (state_s == ST_ISSUE);
            if ((state_r == ST_IDLE) && found_s) begin
                org_x_r    <= org_x_of(pick_s);
                org_y_r    <= org_y_of(pick_s);
                card_num_r <= face_r[pick_s];
                show_r     <= face_up_r[pick_s];
            end
            busy_r        <= (|dirty_s) | (state_s != ST_IDLE);
            frame_done_r  <= (|clr_s) & (dirty_s == {NSLOT{1'b0}});
            timeout_err_r <= timeout_err_r | tmo_hit_s;
        end
    end

    assign draw        = draw_r;
    assign org_x       = org_x_r;
    assign org_y       = org_y_r;
    assign card_num    = card_num_r;
    assign show        = show_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;

endmodule
